// File: rtl/full_adder.sv
// -----------------------------------------------------------------------------
// full_adder
//
// Registered, width-parameterized binary full adder. Computes
// {cout, sum} = a + b + cin through a ripple chain of 1-bit full-adder cells
// and captures the result in a single output register stage. The result is
// available one clock after the operands are accepted.
//
// Parameters:
//   WIDTH      operand / sum width in bits (1..64), default 1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   a, b, cin are accepted on this rising edge
//   a, b       operands (unsigned; two's-complement view used only for ovf)
//   cin        carry into bit 0
//   out_valid  sum/cout (and ovf) hold a newly computed result this cycle
//   sum        low WIDTH bits of a + b + cin
//   cout       carry out of bit WIDTH-1
//   ovf        signed overflow (only when FULL_ADDER_OVERFLOW_EN is defined)
//
// Configuration macro:
//   FULL_ADDER_OVERFLOW_EN  adds the registered ovf output, computed as
//                           carry[WIDTH] ^ carry[WIDTH-1].
// -----------------------------------------------------------------------------
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef FULL_ADDER_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the carry out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    logic             valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Ripple chain: each iteration is one 1-bit full-adder cell.
    // NOTE: every variable driven here gets a value on every path (carry[0]
    // first, then each bit in the loop), so no latch can be inferred.
    always_comb begin
        carry[0] = cin;
        sum_d    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum_d[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout_d = carry[WIDTH];
    end

`ifdef FULL_ADDER_OVERFLOW_EN
    logic ovf_d;
    logic ovf_q;

    // Signed overflow: the carry into the sign bit differs from the carry out.
    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];
`endif

    // Reset wins over in_valid, so an operand set presented with rst is
    // dropped. Without in_valid the result registers simply hold, which also
    // keeps X on idle operands out of the held outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
`ifdef FULL_ADDER_OVERFLOW_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
`ifdef FULL_ADDER_OVERFLOW_EN
                ovf_q  <= ovf_d;
`endif
            end
        end
    end

    assign out_valid = valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef FULL_ADDER_OVERFLOW_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// -----------------------------------------------------------------------------
// tb_full_adder
//
// Self-checking bench for full_adder. Three instances (WIDTH = 1, 8, 16) share
// one clock and reset. Expected values come from plain integer arithmetic on
// the operands (a + b + cin, and a signed-range test for overflow), held in
// bench variables across idle cycles.
// -----------------------------------------------------------------------------
module tb_full_adder;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // WIDTH = 1 instance
    logic        v1_i, a1, b1, c1;
    logic        v1_o, s1, co1;
    // WIDTH = 8 instance
    logic        v8_i, c8, v8_o, co8;
    logic [7:0]  a8, b8, s8;
    // WIDTH = 16 instance
    logic        v16_i, c16, v16_o, co16;
    logic [15:0] a16, b16, s16;
`ifdef FULL_ADDER_OVERFLOW_EN
    logic        ov1, ov8, ov16;
`endif

    full_adder #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1_i), .a(a1), .b(b1), .cin(c1),
        .out_valid(v1_o), .sum(s1), .cout(co1)
`ifdef FULL_ADDER_OVERFLOW_EN
        , .ovf(ov1)
`endif
    );

    full_adder #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8_i), .a(a8), .b(b8), .cin(c8),
        .out_valid(v8_o), .sum(s8), .cout(co8)
`ifdef FULL_ADDER_OVERFLOW_EN
        , .ovf(ov8)
`endif
    );

    full_adder #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v16_i), .a(a16), .b(b16), .cin(c16),
        .out_valid(v16_o), .sum(s16), .cout(co16)
`ifdef FULL_ADDER_OVERFLOW_EN
        , .ovf(ov16)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: full-precision unsigned sum.
    function automatic longint unsigned ref_add(input longint unsigned x, input longint unsigned y,
                                                input logic ci);
        return x + y + longint'(ci);
    endfunction

    // Reference: signed overflow as "true signed result outside the w-bit range".
    function automatic logic ref_ovf(input longint unsigned x, input longint unsigned y,
                                     input logic ci, input int w);
        longint sx, sy, s, lim;
        lim = longint'(1) << (w - 1);
        sx  = (x >= longint'(lim)) ? longint'(x) - 2 * lim : longint'(x);
        sy  = (y >= longint'(lim)) ? longint'(y) - 2 * lim : longint'(y);
        s   = sx + sy + longint'(ci);
        return (s > lim - 1) || (s < -lim);
    endfunction

    // Expected held state of the WIDTH=8 instance.
    logic [8:0]  exp8;
    logic        exp8_ovf;
    logic [16:0] exp16;
    logic        exp16_ovf;

    task automatic check_w8(input string tag, input logic exp_v);
        check({tag, ".sum"},  64'(s8),   64'(exp8[7:0]));
        check({tag, ".cout"}, 64'(co8),  64'(exp8[8]));
        check({tag, ".vld"},  64'(v8_o), 64'(exp_v));
`ifdef FULL_ADDER_OVERFLOW_EN
        check({tag, ".ovf"},  64'(ov8),  64'(exp8_ovf));
`endif
    endtask

    task automatic add8(input logic [7:0] x, input logic [7:0] y, input logic ci);
        v8_i = 1'b1; a8 = x; b8 = y; c8 = ci;
        exp8     = 9'(ref_add(64'(x), 64'(y), ci));
        exp8_ovf = ref_ovf(64'(x), 64'(y), ci, 8);
    endtask

    logic [7:0] tt_sum;
    logic [7:0] tt_cout;

    initial begin
        tt_sum  = 8'b1001_0110;  // spec truth table, entry i at bit i
        tt_cout = 8'b1110_1000;
        v1_i = 0; a1 = 0; b1 = 0; c1 = 0;
        v8_i = 0; a8 = 0; b8 = 0; c8 = 0;
        v16_i = 0; a16 = 0; b16 = 0; c16 = 0;
        exp8 = '0; exp8_ovf = 1'b0; exp16 = '0; exp16_ovf = 1'b0;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst.w1.sum", 64'(s1), 64'd0);
        check("rst.w1.vld", 64'(v1_o), 64'd0);
        check_w8("rst.w8", 1'b0);
        check("rst.w16.sum", 64'({co16, s16}), 64'd0);
        check("rst.w16.vld", 64'(v16_o), 64'd0);

        // First cycle after reset release with no input: still zero.
        rst = 1'b0;
        tick();
        check_w8("post_rst", 1'b0);

        // WIDTH=1 exhaustive, back-to-back, results one cycle later.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] abc;
            abc = 3'(i);
            v1_i = 1'b1; a1 = abc[2]; b1 = abc[1]; c1 = abc[0];
            tick();
            check($sformatf("w1[%0d].sum", i),  64'(s1),   64'(tt_sum[i]));
            check($sformatf("w1[%0d].cout", i), 64'(co1),  64'(tt_cout[i]));
            check($sformatf("w1[%0d].ref", i),  64'({co1, s1}),
                  ref_add(64'(abc[2]), 64'(abc[1]), abc[0]));
            check($sformatf("w1[%0d].vld", i),  64'(v1_o), 64'd1);
`ifdef FULL_ADDER_OVERFLOW_EN
            check($sformatf("w1[%0d].ovf", i),  64'(ov1),
                  64'(ref_ovf(64'(abc[2]), 64'(abc[1]), abc[0], 1)));
`endif
        end
        v1_i = 1'b0;
        tick();
        check("w1.idle.vld", 64'(v1_o), 64'd0);

        // WIDTH=8 carry wrap
        add8(8'hFF, 8'h01, 1'b0);
        tick();
        check_w8("wrap1", 1'b1);
        check("wrap1.lit", 64'({co8, s8}), 64'h100);
        add8(8'hFF, 8'hFF, 1'b1);
        tick();
        check_w8("wrap2", 1'b1);
        check("wrap2.lit", 64'({co8, s8}), 64'h1FF);

        // Hold: one valid add, then 3 idle cycles with random operands.
        add8(8'h12, 8'h34, 1'b0);
        tick();
        check_w8("hold.add", 1'b1);
        check("hold.lit", 64'(s8), 64'h46);
        for (int i = 0; i < 3; i++) begin
            v8_i = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); c8 = 1'($urandom);
            tick();
            check_w8($sformatf("hold[%0d]", i), 1'b0);
        end

`ifdef FULL_ADDER_OVERFLOW_EN
        // Signed overflow cases
        add8(8'h7F, 8'h01, 1'b0);
        tick();
        check_w8("ovf1", 1'b1);
        check("ovf1.lit", 64'({ov8, co8, s8}), 64'h280);
        add8(8'h80, 8'h80, 1'b0);
        tick();
        check_w8("ovf2", 1'b1);
        check("ovf2.lit", 64'({ov8, co8, s8}), 64'h300);
`endif

        // Reset in the same cycle as a valid operand set: operands discarded.
        add8(8'h01, 8'h01, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v8_i = 1'b0;
        exp8 = '0; exp8_ovf = 1'b0;
        check_w8("rst_mid", 1'b0);
        tick();
        check_w8("rst_mid.after", 1'b0);

        // Reset while a result is pending: the pending result never shows.
        add8(8'hA5, 8'h5A, 1'b1);
        tick();
        check_w8("pend.add", 1'b1);
        v8_i = 1'b1; a8 = 8'h33; b8 = 8'h44; c8 = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0; v8_i = 1'b0;
        exp8 = '0; exp8_ovf = 1'b0;
        check_w8("pend.rst", 1'b0);

        // Random regression on WIDTH=16 (state is zero after the resets above).
        exp16 = '0; exp16_ovf = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            logic v;
            v   = 1'($urandom);
            a16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            b16 = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
            c16 = 1'($urandom);
            v16_i = v;
            if (v) begin
                exp16     = 17'(ref_add(64'(a16), 64'(b16), c16));
                exp16_ovf = ref_ovf(64'(a16), 64'(b16), c16, 16);
            end
            tick();
            check($sformatf("rnd[%0d].res", i), 64'({co16, s16}), 64'(exp16));
            check($sformatf("rnd[%0d].vld", i), 64'(v16_o), 64'(v));
`ifdef FULL_ADDER_OVERFLOW_EN
            check($sformatf("rnd[%0d].ovf", i), 64'(ov16), 64'(exp16_ovf));
`endif
        end
        v16_i = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
